serial_subtractor: RTL

Parametrised multi-cycle subtractor computing D = X − Y − Bin over WIDTH-bit operands, BITS_PER_CYCLE bits per clock, LSB slice first, with one borrow register between slices. Each slice is a chain of 1-bit full-subtractor cells. The block sits behind a start/busy/done handshake and is the sequential successor to the combinational 1-bit full subtractor. It trades latency for area in datapaths too wide for a single-cycle ripple chain.

---
 rtl/serial_subtractor.sv | 131 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: D = X - Y - Bin, BITS_PER_CYCLE bits per clock, LSB slice first,
// with a single borrow register carrying between slices and a start/busy/done handshake.
module serial_subtractor #(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             ovf
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    generate
        if (WIDTH < 1 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
            $error("serial_subtractor: BITS_PER_CYCLE must be >=1 and divide WIDTH");
        end
    endgenerate

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] xs_q, xs_d;
    logic [WIDTH-1:0] ys_q, ys_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    // Ripple chain of full-subtractor cells over the low slice of the operand shifters.
    logic [BITS_PER_CYCLE:0]   bc;
    logic [BITS_PER_CYCLE-1:0] sd;
    logic [WIDTH-1:0]          res_nxt;

    always_comb begin
        bc    = '0;
        sd    = '0;
        bc[0] = brw_q;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            sd[i]   = xs_q[i] ^ ys_q[i] ^ bc[i];
            bc[i+1] = (~xs_q[i] & ys_q[i]) | (~(xs_q[i] ^ ys_q[i]) & bc[i]);
        end
    end

    // Slice difference enters the result shifter from the top.
    assign res_nxt = WIDTH'({sd, res_q} >> BITS_PER_CYCLE);

    always_comb begin
        state_d = state_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        res_d   = res_q;
        brw_d   = brw_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    xs_d    = x;
                    ys_d    = y;
                    brw_d   = bin;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                xs_d  = xs_q >> BITS_PER_CYCLE;
                ys_d  = ys_q >> BITS_PER_CYCLE;
                res_d = res_nxt;
                brw_d = bc[BITS_PER_CYCLE];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    dout_d  = res_nxt;
                    bout_d  = bc[BITS_PER_CYCLE];
                    ovf_d   = bc[BITS_PER_CYCLE-1] ^ bc[BITS_PER_CYCLE];
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            xs_q    <= '0;
            ys_q    <= '0;
            res_q   <= '0;
            brw_q   <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            res_q   <= res_d;
            brw_q   <= brw_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign d    = dout_q;
    assign bout = bout_q;
    assign ovf  = ovf_q;

endmodule
